// File: rtl/mem_burst_ctrl.sv
// Burst sequencer: expands one (addr, len, dir) command into per-beat strobes for a
// single-port memory with one-cycle registered response. Optional macro: MEM_BURST_BOUND_EN.
module mem_burst_ctrl #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 64,
  parameter int ADDR  = $clog2(DEPTH),
  parameter int LEN_W = 4
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_wr_i,
  input  logic [ADDR-1:0]  cmd_addr_i,
  input  logic [LEN_W-1:0] cmd_len_i,
  input  logic             wdata_valid_i,
  output logic             wdata_ready_o,
  input  logic [WIDTH-1:0] wdata_i,
  output logic             rdata_valid_o,
  input  logic             rdata_ready_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             rdata_last_o,
  output logic             done_o,
  output logic             err_o,
  output logic             mem_valid_o,
  output logic             mem_wr_rd_o,
  output logic [ADDR-1:0]  mem_addr_o,
  output logic [WIDTH-1:0] mem_wdata_o,
  input  logic [WIDTH-1:0] mem_rdata_i,
  input  logic             mem_ready_i,
  output logic [2:0]       dbg_state_o
);

  typedef enum logic [2:0] {S_IDLE, S_WRITE, S_READ, S_DRAIN, S_DONE} state_t;

  state_t           r_state, w_next;
  logic [ADDR-1:0]  r_cur, w_cur_inc;
  logic [LEN_W:0]   r_left;
  logic [LEN_W:0]   r_rsp_left;
  logic [1:0]       r_inflight;
  logic [1:0]       r_occ;
  logic             r_wptr, r_rptr;
  logic [WIDTH-1:0] r_fifo_data [2];
  logic [1:0]       r_fifo_last;
  logic             r_mem_valid, r_mem_wr_rd;
  logic [ADDR-1:0]  r_mem_addr;
  logic [WIDTH-1:0] r_mem_wdata;

  logic w_cmd_hs, w_cmd_reject, w_cmd_go;
  logic w_wr_beat, w_rd_issue, w_issue, w_capture, w_pop;

  // All streams: a transfer happens on a clock edge where valid and ready are both high;
  // valid never waits on ready, and payload is held while valid & !ready.
  assign cmd_ready_o   = rst_i && (r_state == S_IDLE);
  assign wdata_ready_o = (r_state == S_WRITE);
  assign done_o        = (r_state == S_DONE);
  assign rdata_valid_o = (r_occ != 2'd0);
  assign rdata_o       = r_fifo_data[r_rptr];
  assign rdata_last_o  = rdata_valid_o && r_fifo_last[r_rptr];
  assign mem_valid_o   = r_mem_valid;
  assign mem_wr_rd_o   = r_mem_wr_rd;
  assign mem_addr_o    = r_mem_addr;
  assign mem_wdata_o   = r_mem_wdata;
  assign dbg_state_o   = r_state;

  assign w_cmd_hs  = cmd_valid_i && (r_state == S_IDLE);
  assign w_cmd_go  = w_cmd_hs && !w_cmd_reject;
  assign w_issue   = w_wr_beat || w_rd_issue;
  assign w_capture = mem_ready_i && (r_inflight != 2'd0);
  assign w_pop     = rdata_valid_o && rdata_ready_i;
  assign w_cur_inc = (r_cur == ADDR'(DEPTH - 1)) ? '0 : r_cur + 1'b1;

`ifdef MEM_BURST_BOUND_EN
  localparam int SUM_W = ADDR + LEN_W + 1;
  logic [SUM_W-1:0] w_end;
  logic             r_err;
  assign w_end        = SUM_W'(cmd_addr_i) + SUM_W'(cmd_len_i);
  assign w_cmd_reject = w_cmd_hs && (w_end > SUM_W'(DEPTH - 1));
  assign err_o        = r_err;

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) r_err <= 1'b0;
    else        r_err <= w_cmd_reject;
  end
`else
  assign w_cmd_reject = 1'b0;
  assign err_o        = 1'b0;
`endif

  always_comb begin
    w_next     = r_state;
    w_wr_beat  = 1'b0;
    w_rd_issue = 1'b0;
    case (r_state)
      S_IDLE:  if (w_cmd_go) w_next = cmd_wr_i ? S_WRITE : S_READ;
      S_WRITE: begin
        if (wdata_valid_i) begin
          w_wr_beat = 1'b1;
          if (r_left == (LEN_W+1)'(1)) w_next = S_DONE;
        end
      end
      S_READ: begin
        // A read may only issue if its response is guaranteed a FIFO slot.
        if (({1'b0, r_occ} + {1'b0, r_inflight}) < 3'd2) begin
          w_rd_issue = 1'b1;
          if (r_left == (LEN_W+1)'(1)) w_next = S_DRAIN;
        end
      end
      S_DRAIN: if (r_inflight == 2'd0) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      r_state        <= S_IDLE;
      r_cur          <= '0;
      r_left         <= '0;
      r_rsp_left     <= '0;
      r_inflight     <= '0;
      r_occ          <= '0;
      r_wptr         <= 1'b0;
      r_rptr         <= 1'b0;
      r_fifo_data[0] <= '0;
      r_fifo_data[1] <= '0;
      r_fifo_last    <= '0;
      r_mem_valid    <= 1'b0;
      r_mem_wr_rd    <= 1'b0;
      r_mem_addr     <= '0;
      r_mem_wdata    <= '0;
    end else begin
      r_state     <= w_next;
      r_mem_valid <= w_issue;
      if (w_cmd_go) begin
        r_cur  <= cmd_addr_i;
        r_left <= (LEN_W+1)'(cmd_len_i) + (LEN_W+1)'(1);
        if (!cmd_wr_i) r_rsp_left <= (LEN_W+1)'(cmd_len_i) + (LEN_W+1)'(1);
      end
      if (w_issue) begin
        r_cur       <= w_cur_inc;
        r_left      <= r_left - (LEN_W+1)'(1);
        r_mem_wr_rd <= w_wr_beat;
        r_mem_addr  <= r_cur;
        if (w_wr_beat) r_mem_wdata <= wdata_i;
      end
      case ({w_rd_issue, w_capture})
        2'b10:   r_inflight <= r_inflight + 2'd1;
        2'b01:   r_inflight <= r_inflight - 2'd1;
        default: r_inflight <= r_inflight;
      endcase
      if (w_capture) begin
        r_fifo_data[r_wptr] <= mem_rdata_i;
        r_fifo_last[r_wptr] <= (r_rsp_left == (LEN_W+1)'(1));
        r_wptr              <= ~r_wptr;
        r_rsp_left          <= r_rsp_left - (LEN_W+1)'(1);
      end
      if (w_pop) r_rptr <= ~r_rptr;
      case ({w_capture, w_pop})
        2'b10:   r_occ <= r_occ + 2'd1;
        2'b01:   r_occ <= r_occ - 2'd1;
        default: r_occ <= r_occ;
      endcase
    end
  end

endmodule
